bresenham_line_engine: RTL and testbench
========================================

Name: bresenham_line_engine

Overview:
- Responder side of the line-draw handshake driven by the Bresenham line controller.
- Accepts one line request (draw_en plus x0,y0,x1,y1), rasterises it with integer Bresenham stepping, and streams one pixel coordinate per accepted handshake to the frame-buffer write path.
- Pulses draw_done once the last pixel has been accepted. The controller uses draw_done to advance to the next edge of a triangle.

Parameters:
- COORD_W, 8, width of every coordinate (screen is 0..2^COORD_W-1 on each axis).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- draw_en  input  1  line request. Level signal, held high by the controller until it sees draw_done.
- x0  input  COORD_W  start x.
- y0  input  COORD_W  start y.
- x1  input  COORD_W  end x.
- y1  input  COORD_W  end y.
- pixel_ready  input  1  downstream can accept a pixel this cycle.
- pixel_valid  output  1  pixel_x/pixel_y hold a pixel to write.
- pixel_x  output  COORD_W  pixel x coordinate.
- pixel_y  output  COORD_W  pixel y coordinate.
- draw_done  output  1  one-cycle pulse: line complete.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: with rst high at a clock edge, state goes to IDLE and pixel_valid, pixel_x, pixel_y, draw_done and busy all go to 0. This applies mid-line too: the line is abandoned and no draw_done is issued.
- States: IDLE, SETUP, PLOT, DONE, REARM.
- IDLE: if draw_en=1, latch x0,y0,x1,y1 into internal registers and go to SETUP. Inputs are not sampled again until the next IDLE.
- SETUP (1 cycle), using signed 11-bit arithmetic throughout:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1
  - err = dx+dy; cur = (x0,y0)
  - next state: PLOT.
- PLOT:
  - pixel_valid=1 and pixel_x/pixel_y = cur. These stay stable while pixel_ready=0.
  - On the handshake cycle (valid & ready): if cur==(x1,y1), go to DONE. Otherwise, with e2 = 2*err:
    - if e2 >= dy: err += dy, cur.x += sx
    - if e2 <= dx: err += dx, cur.y += sy
    - both updates use the pre-update err within the same cycle.
- DONE: draw_done=1 for exactly one cycle, pixel_valid=0, then go to REARM.
- REARM: wait for draw_en=0, then go to IDLE. This stops a still-high draw_en from restarting the same line; the controller drops draw_en for at least one cycle between edges.
- Latency: draw_en sampled in IDLE at edge N gives the first pixel_valid in cycle N+2. With ready held high, one pixel per cycle. draw_done is high in the cycle after the final handshake.
- Pixel count = max(dx,|dy|)+1, endpoints inclusive.
- cur never leaves the bounding box of the endpoints. There is no wrap at 0 or 2^COORD_W-1.
- draw_en falling during SETUP/PLOT is ignored; the latched line completes.
- Input changes after latching are ignored.
- busy=1 in SETUP, PLOT, DONE, REARM.

Optional Feature:
- Macro: BRESENHAM_SKIP_LAST_EN.
- Defined:
  - The final endpoint (x1,y1) is not emitted, so triangle vertices shared between edges are not double-written.
  - When the handshake for the pixel before the endpoint completes, go to DONE.
  - A degenerate line (x0==x1 && y0==y1) goes SETUP→DONE with zero pixels.
  - Pixel count = max(dx,|dy|).
- Undefined: endpoints inclusive, as described above.

Test Plan:
- Horizontal (0,0)→(5,0), ready=1 → pixels (0,0)..(5,0) on 6 consecutive cycles starting 2 cycles after draw_en; draw_done single pulse the following cycle; busy falls once draw_en drops.
- Steep reverse (3,10)→(1,4), ready=1 → exactly (3,10),(3,9),(2,8),(2,7),(2,6),(1,5),(1,4), then draw_done. With BRESENHAM_SKIP_LAST_EN: the first 6 only.
- Degenerate (7,7)→(7,7) → single pixel (7,7) then draw_done. With the macro: no pixel_valid, draw_done 2 cycles after draw_en.
- Backpressure: diagonal (0,0)→(3,3) with pixel_ready pattern 1,0,0,1,0,1,1 → pixel_x/pixel_y stable while not ready; (0,0),(1,1),(2,2),(3,3) each accepted exactly once; draw_done only after the last acceptance.
- Full range (0,255)→(255,0) → 256 pixels, x strictly increasing 0..255, y decreasing 255..0, no wrap.
- Control cases:
  - Hold draw_en high 5 cycles after draw_done → no second line.
  - Drop draw_en 1 cycle and raise with new coordinates → new line starts.
  - Assert rst on the 3rd pixel of (0,0)→(9,0) → next cycle all outputs 0, no draw_done.

Source files
------------

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: latches one line request and streams its pixels over a valid/ready handshake.
// Define BRESENHAM_SKIP_LAST_EN to suppress the final endpoint so shared triangle vertices are written once.
module bresenham_line_engine #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pixel_ready,
    output logic               pixel_valid,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               draw_done,
    output logic               busy
);

    // Three extra bits cover the sign plus 2*err without overflow.
    localparam int SW = COORD_W + 3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PLOT,
        DONE,
        REARM
    } state_t;

    state_t state;

    logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic signed [SW-1:0] dx, dy, err;
    logic step_x_pos, step_y_pos;

    logic signed [SW-1:0] ex0, ey0, ex1, ey1;
    logic signed [SW-1:0] setup_dx, setup_dy;
    logic signed [SW-1:0] e2, next_err;
    logic move_x, move_y;
    logic [COORD_W-1:0] next_x, next_y;
`ifdef BRESENHAM_SKIP_LAST_EN
    logic next_at_end;
    logic degenerate;
`else
    logic at_end;
`endif

    always_comb begin
        ex0 = {{(SW-COORD_W){1'b0}}, lx0};
        ey0 = {{(SW-COORD_W){1'b0}}, ly0};
        ex1 = {{(SW-COORD_W){1'b0}}, lx1};
        ey1 = {{(SW-COORD_W){1'b0}}, ly1};
        setup_dx = (ex1 > ex0) ? (ex1 - ex0) : (ex0 - ex1);
        setup_dy = (ey1 > ey0) ? (ey0 - ey1) : (ey1 - ey0);

        // Both axis decisions use the pre-update error term.
        e2       = err <<< 1;
        move_x   = (e2 >= dy);
        move_y   = (e2 <= dx);
        next_err = err + (move_x ? dy : '0) + (move_y ? dx : '0);
        next_x   = cur_x;
        next_y   = cur_y;
        if (move_x) next_x = step_x_pos ? cur_x + COORD_W'(1) : cur_x - COORD_W'(1);
        if (move_y) next_y = step_y_pos ? cur_y + COORD_W'(1) : cur_y - COORD_W'(1);
`ifdef BRESENHAM_SKIP_LAST_EN
        next_at_end = (next_x == lx1) && (next_y == ly1);
        degenerate  = (lx0 == lx1) && (ly0 == ly1);
`else
        at_end      = (cur_x == lx1) && (cur_y == ly1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            draw_done   <= 1'b0;
            busy        <= 1'b0;
            lx0         <= '0;
            ly0         <= '0;
            lx1         <= '0;
            ly1         <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            step_x_pos  <= 1'b0;
            step_y_pos  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_en) begin
                        lx0   <= x0;
                        ly0   <= y0;
                        lx1   <= x1;
                        ly1   <= y1;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx         <= setup_dx;
                    dy         <= setup_dy;
                    err        <= setup_dx + setup_dy;
                    step_x_pos <= (lx0 < lx1);
                    step_y_pos <= (ly0 < ly1);
                    cur_x      <= lx0;
                    cur_y      <= ly0;
`ifdef BRESENHAM_SKIP_LAST_EN
                    if (degenerate) begin
                        draw_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        pixel_valid <= 1'b1;
                        pixel_x     <= lx0;
                        pixel_y     <= ly0;
                        state       <= PLOT;
                    end
`else
                    pixel_valid <= 1'b1;
                    pixel_x     <= lx0;
                    pixel_y     <= ly0;
                    state       <= PLOT;
`endif
                end
                PLOT: begin
                    if (pixel_ready) begin
`ifdef BRESENHAM_SKIP_LAST_EN
                        if (next_at_end) begin
`else
                        if (at_end) begin
`endif
                            pixel_valid <= 1'b0;
                            draw_done   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            err     <= next_err;
                            cur_x   <= next_x;
                            cur_y   <= next_y;
                            pixel_x <= next_x;
                            pixel_y <= next_y;
                        end
                    end
                end
                DONE: begin
                    draw_done <= 1'b0;
                    state     <= REARM;
                end
                REARM: begin
                    // A still-high request belongs to the line just finished.
                    if (!draw_en) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    pixel_valid <= 1'b0;
                    draw_done   <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Self-checking bench for bresenham_line_engine: directed line cases plus randomized lines against a textbook Bresenham model.
// Honours BRESENHAM_SKIP_LAST_EN by dropping the final endpoint from every expected pixel list.
module tb_bresenham_line_engine;

    localparam int COORD_W = 8;
`ifdef BRESENHAM_SKIP_LAST_EN
    localparam bit SKIP_LAST = 1'b1;
`else
    localparam bit SKIP_LAST = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               draw_en;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic               pixel_ready;
    logic               pixel_valid;
    logic [COORD_W-1:0] pixel_x, pixel_y;
    logic               draw_done;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int exp_x[$];
    int exp_y[$];
    int ready_pat[$];

    bresenham_line_engine #(.COORD_W(COORD_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .draw_en     (draw_en),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .draw_done   (draw_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void drop_last_if_skipping();
        if (SKIP_LAST && exp_x.size() > 0) begin
            void'(exp_x.pop_back());
            void'(exp_y.pop_back());
        end
    endfunction

    // Textbook integer Bresenham on plain ints, endpoints inclusive.
    function automatic void build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dxm, dym, sx, sy, e, e2, x, y;
        exp_x.delete();
        exp_y.delete();
        dxm = iabs(ax1 - ax0);
        dym = -iabs(ay1 - ay0);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        e   = dxm + dym;
        x   = ax0;
        y   = ay0;
        for (int n = 0; n < 1024; n++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * e;
            if (e2 >= dym) begin e = e + dym; x = x + sx; end
            if (e2 <= dxm) begin e = e + dxm; y = y + sy; end
        end
        drop_last_if_skipping();
    endfunction

    // Drives one line request; rmode 0 = ready always, 1 = random ready, 2 = ready_pat from first pixel.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int rmode, input int hold, input string name);
        int cycle = 0;
        int first = -1;
        int idx = 0;
        int last_acc = -1;
        int k;
        int want_cycle;
        bit finished = 1'b0;
        bit prev_stall = 1'b0;
        bit rdy;
        logic [COORD_W-1:0] prev_x = '0;
        logic [COORD_W-1:0] prev_y = '0;

        x0 = COORD_W'(ax0);
        y0 = COORD_W'(ay0);
        x1 = COORD_W'(ax1);
        y1 = COORD_W'(ay1);
        draw_en = 1'b1;
        pixel_ready = 1'b0;
        while (!finished && cycle < 3000) begin
            @(posedge clk);
            @(negedge clk);
            cycle++;
            if (cycle == 1) begin
                x0 = COORD_W'($urandom);
                y0 = COORD_W'($urandom);
                x1 = COORD_W'($urandom);
                y1 = COORD_W'($urandom);
            end
            if (first < 0 && (pixel_valid === 1'b1 || draw_done === 1'b1)) first = cycle;
            k = (first >= 0) ? cycle - first : 0;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (k < ready_pat.size()) ? (ready_pat[k] != 0) : 1'b1;
            endcase
            pixel_ready = rdy;

            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s busy_active cycle %0d: got %b expected 1", name, cycle, busy);
            end
            if (prev_stall) begin
                checks++;
                if (pixel_valid !== 1'b1 || pixel_x !== prev_x || pixel_y !== prev_y) begin
                    errors++;
                    $display("[TB] FAIL %s stall_hold cycle %0d: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                             name, cycle, pixel_valid, pixel_x, pixel_y, prev_x, prev_y);
                end
            end
            if (pixel_valid === 1'b1 && rdy) begin
                checks++;
                if (idx >= exp_x.size()) begin
                    errors++;
                    $display("[TB] FAIL %s extra_pixel #%0d: got (%0d,%0d) expected no pixel",
                             name, idx, pixel_x, pixel_y);
                end else if (pixel_x !== COORD_W'(exp_x[idx]) || pixel_y !== COORD_W'(exp_y[idx])) begin
                    errors++;
                    $display("[TB] FAIL %s pixel #%0d: got (%0d,%0d) expected (%0d,%0d)",
                             name, idx, pixel_x, pixel_y, exp_x[idx], exp_y[idx]);
                end
                idx++;
                last_acc = cycle;
            end
            if (draw_done === 1'b1) begin
                want_cycle = (last_acc < 0) ? 2 : last_acc + 1;
                checks++;
                if (cycle != want_cycle) begin
                    errors++;
                    $display("[TB] FAIL %s done_timing: got cycle %0d expected cycle %0d", name, cycle, want_cycle);
                end
                checks++;
                if (pixel_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s valid_at_done: got %b expected 0", name, pixel_valid);
                end
                finished = 1'b1;
            end
            prev_stall = (pixel_valid === 1'b1) && !rdy;
            prev_x = pixel_x;
            prev_y = pixel_y;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s done_timeout: got no draw_done after %0d cycles expected one", name, cycle);
        end
        checks++;
        if (idx != exp_x.size()) begin
            errors++;
            $display("[TB] FAIL %s pixel_count: got %0d expected %0d", name, idx, exp_x.size());
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("[TB] FAIL %s first_output_latency: got %0d expected 2", name, first);
        end

        // Keep the request high after completion; the same line must not restart.
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            pixel_ready = 1'b1;
            checks++;
            if (draw_done !== 1'b0 || pixel_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s rearm_hold %0d: got done=%b valid=%b busy=%b expected 0 0 1",
                         name, i, draw_done, pixel_valid, busy);
            end
        end
        draw_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s back_to_idle: got busy=%b valid=%b expected 0 0", name, busy, pixel_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        draw_en = 1'b0;
        pixel_ready = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 || draw_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b x=%0d y=%0d done=%b busy=%b expected all 0",
                     pixel_valid, pixel_x, pixel_y, draw_done, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        exp_x.delete(); exp_y.delete();
        for (int i = 0; i <= 5; i++) begin exp_x.push_back(i); exp_y.push_back(0); end
        drop_last_if_skipping();
        run_line(0, 0, 5, 0, 0, 1, "horizontal");
    endtask

    task automatic test_steep_reverse();
        int xs[7] = '{3, 3, 2, 2, 2, 1, 1};
        int ys[7] = '{10, 9, 8, 7, 6, 5, 4};
        exp_x.delete(); exp_y.delete();
        for (int i = 0; i < 7; i++) begin exp_x.push_back(xs[i]); exp_y.push_back(ys[i]); end
        drop_last_if_skipping();
        run_line(3, 10, 1, 4, 0, 1, "steep_reverse");
    endtask

    task automatic test_degenerate();
        exp_x.delete(); exp_y.delete();
        exp_x.push_back(7); exp_y.push_back(7);
        drop_last_if_skipping();
        run_line(7, 7, 7, 7, 0, 1, "degenerate");
    endtask

    task automatic test_backpressure();
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        ready_pat.delete();
        for (int i = 0; i < 7; i++) ready_pat.push_back(pat[i]);
        exp_x.delete(); exp_y.delete();
        for (int i = 0; i <= 3; i++) begin exp_x.push_back(i); exp_y.push_back(i); end
        drop_last_if_skipping();
        run_line(0, 0, 3, 3, 2, 1, "backpressure");
    endtask

    task automatic test_full_range();
        exp_x.delete(); exp_y.delete();
        for (int i = 0; i <= 255; i++) begin exp_x.push_back(i); exp_y.push_back(255 - i); end
        drop_last_if_skipping();
        run_line(0, 255, 255, 0, 0, 1, "full_range");
    endtask

    task automatic test_back_to_back();
        build_model(2, 3, 6, 1);
        run_line(2, 3, 6, 1, 0, 5, "hold_high");
        build_model(10, 20, 4, 22);
        run_line(10, 20, 4, 22, 0, 1, "rearm_new_line");
    endtask

    task automatic test_reset_mid_line();
        bit hit = 1'b0;
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0;
        draw_en = 1'b1;
        pixel_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (pixel_valid === 1'b1 && pixel_x === 8'd2) begin
                rst = 1'b1;
                draw_en = 1'b0;
                hit = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL reset_mid_line third_pixel: got none within 20 cycles expected pixel (2,0)");
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pixel_valid !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 || draw_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_line outputs: got v=%b x=%0d y=%0d done=%b busy=%b expected all 0",
                     pixel_valid, pixel_x, pixel_y, draw_done, busy);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (draw_done !== 1'b0 || pixel_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid_line quiet %0d: got done=%b valid=%b busy=%b expected 0 0 0",
                         c, draw_done, pixel_valid, busy);
            end
        end
    endtask

    task automatic test_random_lines();
        int ax0, ay0, ax1, ay1;
        for (int n = 0; n < 24; n++) begin
            ax0 = $urandom_range(0, 255);
            ay0 = $urandom_range(0, 255);
            if (n % 2 == 0) begin
                ax1 = $urandom_range(0, 255);
                ay1 = $urandom_range(0, 255);
            end else begin
                ax1 = ax0 + $urandom_range(0, 12) - 6;
                ay1 = ay0 + $urandom_range(0, 12) - 6;
                if (ax1 < 0) ax1 = 0;
                if (ax1 > 255) ax1 = 255;
                if (ay1 < 0) ay1 = 0;
                if (ay1 > 255) ay1 = 255;
            end
            build_model(ax0, ay0, ax1, ay1);
            run_line(ax0, ay0, ax1, ay1, 1, $urandom_range(1, 3), $sformatf("random_%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep_reverse();
        test_degenerate();
        test_backpressure();
        test_full_range();
        test_back_to_back();
        test_reset_mid_line();
        test_random_lines();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
